vga_fetch_sched: RTL and testbench



---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_fetch_sched_if.sv | 34 +++
 rtl/vga_credit_cnt.sv | 45 ++++
 rtl/vga_fetch_sched.sv | 157 +++++++++++++++
 tb/tb_vga_fetch_sched.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : vga_pkg                                                  |
// | Shared VGA timing constants, fetch defaults and the fetch FSM type |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
package vga_pkg;

  // Horizontal / vertical blanking geometry of the timing generator
  localparam int HFP    = 40;
  localparam int HPULSE = 48;
  localparam int HBP    = 40;
  localparam int VFP    = 13;
  localparam int VPULSE = 3;
  localparam int VBP    = 29;

  // Default burst size in pixels and the byte size of one pixel word
  localparam int DEFAULT_BURST   = 16;
  localparam int BYTES_PER_PIXEL = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    FETCH = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_fetch_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface : vga_fetch_sched_if                                     |
// | Burst read request / completion bus to the memory read master      |
// | Rev 1.0   : initial release                                        |
// +--------------------------------------------------------------------+
interface vga_fetch_sched_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;
  logic              req_ready;
  logic              rsp_done;

  // Scheduler side: issues requests, sees acceptance and completions
  modport master (
    output req_valid,
    output req_addr,
    output req_len,
    input  req_ready,
    input  rsp_done
  );

  // Read-master side
  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_len,
    output req_ready,
    output rsp_done
  );
endinterface
`default_nettype wire

// File: rtl/vga_credit_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : vga_credit_cnt                                            |
// | Up/down in-flight burst counter, simultaneous inc/dec, floor at 0  |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module vga_credit_cnt #(
  parameter int W = 5
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         inc_i,
  input  wire logic         dec_i,
  output logic [W-1:0]      cnt_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         w_dec_eff;

  // A completion with nothing outstanding is stale and must not underflow
  assign w_dec_eff = dec_i && (cnt_q != '0);

  // Next count: inc and dec together cancel out
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !w_dec_eff) begin
      cnt_d = cnt_q + W'(1);
    end else if (!inc_i && w_dec_eff) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/vga_fetch_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : vga_fetch_sched                                           |
// | Frame-aligned burst read scheduler feeding the VGA pixel FIFO      |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module vga_fetch_sched
  import vga_pkg::*;
#(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int BURST      = DEFAULT_BURST,
  parameter int FIFO_DEPTH = 256,
  parameter int ADDR_W     = 32
) (
  input  wire logic                          pixel_clk,
  input  wire logic                          pixel_rst,
  input  wire logic                          enable,
  input  wire logic [ADDR_W-1:0]             fb_base,
  input  wire logic                          vs_in,
  input  wire logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  vga_fetch_sched_if.master                  req_bus,
  output logic                               frame_active,
  output logic                               frame_done,
  output logic                               err_overrun
);

  localparam int c_frame_bursts = HDISP * VDISP / BURST;
  localparam int c_rem_w        = $clog2(c_frame_bursts + 1);
  localparam int c_cnt_w        = $clog2(FIFO_DEPTH / BURST + 1);
  localparam logic [ADDR_W-1:0] c_addr_step = ADDR_W'(BURST * BYTES_PER_PIXEL);
  localparam logic [31:0]       c_burst_32  = 32'(BURST);
  localparam logic [31:0]       c_depth_32  = 32'(FIFO_DEPTH);

  fetch_state_t         state_q, state_d;
  logic                 req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
  logic [c_rem_w-1:0]   remaining_q, remaining_d;
  logic                 frame_active_q, frame_active_d;
  logic                 frame_done_q, frame_done_d;
  logic                 err_overrun_q, err_overrun_d;
  logic                 vs_prev_q;

  logic [c_cnt_w-1:0]   inflight;
  logic                 w_vs_fall;
  logic                 w_handshake;
  logic [31:0]          w_need;
  logic                 w_credit_ok;

  assign w_vs_fall   = vs_prev_q && !vs_in;
  assign w_handshake = req_valid_q && req_bus.req_ready;

  // Room for one more burst on top of what is buffered and already in flight
  assign w_need      = 32'(fifo_level) + (32'(inflight) + 32'd1) * c_burst_32;
  assign w_credit_ok = (w_need <= c_depth_32);

  vga_credit_cnt #(
    .W (c_cnt_w)
  ) u_credit (
    .clk   (pixel_clk),
    .rst   (pixel_rst),
    .inc_i (w_handshake),
    .dec_i (req_bus.rsp_done),
    .cnt_o (inflight)
  );

  // Next-state and datapath updates for the frame fetch sequence
  always_comb begin
    state_d        = state_q;
    req_valid_d    = req_valid_q;
    req_addr_d     = req_addr_q;
    remaining_d    = remaining_q;
    frame_active_d = frame_active_q;
    frame_done_d   = 1'b0;
    err_overrun_d  = err_overrun_q;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SYNC;
        end
      end
      SYNC: begin
        // A disabled scheduler never starts a frame, even on a VS edge
        if (!enable) begin
          state_d = IDLE;
        end else if (w_vs_fall) begin
          state_d        = FETCH;
          req_addr_d     = fb_base;
          remaining_d    = c_rem_w'(c_frame_bursts);
          frame_active_d = 1'b1;
        end
      end
      FETCH: begin
        if (w_vs_fall) begin
          err_overrun_d = 1'b1;
        end
        if (w_handshake) begin
          req_valid_d = 1'b0;
          req_addr_d  = req_addr_q + c_addr_step;
          remaining_d = remaining_q - c_rem_w'(1);
          if (remaining_q == c_rem_w'(1)) begin
            state_d = DRAIN;
          end
        end else if (!req_valid_q && (remaining_q != '0) && w_credit_ok) begin
          // Credit is only evaluated before raising valid; once up it holds
          req_valid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (w_vs_fall) begin
          err_overrun_d = 1'b1;
        end
        if (inflight == '0) begin
          frame_done_d   = 1'b1;
          frame_active_d = 1'b0;
          state_d        = enable ? SYNC : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state_q        <= IDLE;
      req_valid_q    <= 1'b0;
      req_addr_q     <= '0;
      remaining_q    <= '0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      err_overrun_q  <= 1'b0;
      vs_prev_q      <= 1'b1;
    end else begin
      state_q        <= state_d;
      req_valid_q    <= req_valid_d;
      req_addr_q     <= req_addr_d;
      remaining_q    <= remaining_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      err_overrun_q  <= err_overrun_d;
      vs_prev_q      <= vs_in;
    end
  end

  assign req_bus.req_valid = req_valid_q;
  assign req_bus.req_addr  = req_addr_q;
  assign req_bus.req_len   = 8'(BURST);
  assign frame_active      = frame_active_q;
  assign frame_done        = frame_done_q;
  assign err_overrun       = err_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fetch_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_vga_fetch_sched                                        |
// | Directed scoreboard bench for vga_fetch_sched                      |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module tb_vga_fetch_sched;
  import vga_pkg::*;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] fb_base;
  logic        vs_in;
  logic [6:0]  fifo_level;
  logic        frame_active;
  logic        frame_done;
  logic        err_overrun;

  logic        auto_en;
  logic        auto_rsp;
  logic        man_rsp;
  logic [2:0]  pend;

  int          checks;
  int          failures;
  int          accepts;
  int          fd_count;
  int          acc0;
  logic [63:0] sb [$];
  logic [63:0] exp_addr;

  vga_fetch_sched_if #(.ADDR_W(32)) bus ();

  assign bus.rsp_done = auto_rsp | man_rsp;

  vga_fetch_sched #(
    .HDISP      (32),
    .VDISP      (4),
    .BURST      (16),
    .FIFO_DEPTH (64),
    .ADDR_W     (32)
  ) dut (
    .pixel_clk    (clk),
    .pixel_rst    (rst),
    .enable       (enable),
    .fb_base      (fb_base),
    .vs_in        (vs_in),
    .fifo_level   (fifo_level),
    .req_bus      (bus),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .err_overrun  (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [31:0] base);
    for (int i = 0; i < 8; i++) sb.push_back(64'(base + 32'(i * 64)));
  endtask

  task automatic wait_req_valid(input int budget, input string tag);
    int n = 0;
    while (bus.req_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(bus.req_valid), 64'd1);
    tick(1);
  endtask

  task automatic wait_frame_done(input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < budget);
    chk(tag, 64'(frame_done), 64'd1);
    chk({tag, "_active_low"}, 64'(frame_active), 64'd0);
    tick(1);
  endtask

  // Monitor: scoreboard on every accept, auto completion 3 cycles later
  always @(negedge clk) begin
    auto_rsp = auto_en && pend[2];
    pend = {pend[1:0], (auto_en && bus.req_valid && bus.req_ready)};
    if (frame_done === 1'b1) fd_count++;
    if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) begin
      accepts++;
      exp_addr = '1;
      if (sb.size() != 0) exp_addr = sb.pop_front();
      chk("req_addr", 64'(bus.req_addr), exp_addr);
      chk("req_len", 64'(bus.req_len), 64'd16);
    end
  end

  initial begin
    checks = 0; failures = 0; accepts = 0; fd_count = 0;
    auto_en = 1'b0; auto_rsp = 1'b0; man_rsp = 1'b0; pend = 3'b000;
    rst = 1'b1; enable = 1'b0; fb_base = 32'h0; vs_in = 1'b1;
    fifo_level = 7'd0; bus.req_ready = 1'b1;
    tick(3);

    // Reset state
    chk("rst_valid", 64'(bus.req_valid), 64'd0);
    chk("rst_addr", 64'(bus.req_addr), 64'd0);
    chk("rst_active", 64'(frame_active), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_ovr", 64'(err_overrun), 64'd0);
    chk("rst_inflight", 64'(dut.inflight), 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(IDLE));

    // Nominal frame
    rst = 1'b0; enable = 1'b1; fb_base = 32'h1000; auto_en = 1'b1;
    tick(2);
    chk("sync_state", 64'(dut.state_q), 64'(SYNC));
    push_frame(32'h1000);
    vs_in = 1'b0;
    tick(1);
    chk("nom_active", 64'(frame_active), 64'd1);
    tick(2);
    vs_in = 1'b1;
    wait_frame_done(200, "nom_done");
    tick(5);
    chk("nom_fd_once", 64'(fd_count), 64'd1);
    chk("nom_accepts", 64'(accepts), 64'd8);
    chk("nom_sb_empty", 64'(sb.size()), 64'd0);
    chk("nom_state", 64'(dut.state_q), 64'(SYNC));

    // Credit limit
    auto_en = 1'b0; fifo_level = 7'd40; fb_base = 32'h2000;
    acc0 = accepts;
    push_frame(32'h2000);
    vs_in = 1'b0;
    tick(1);
    vs_in = 1'b1;
    tick(10);
    chk("cred_one_req", 64'(accepts - acc0), 64'd1);
    chk("cred_valid_low", 64'(bus.req_valid), 64'd0);
    chk("cred_inflight", 64'(dut.inflight), 64'd1);
    man_rsp = 1'b1;
    tick(1);
    man_rsp = 1'b0;
    tick(5);
    chk("cred_second_req", 64'(accepts - acc0), 64'd2);

    // Backpressure with valid held against a fifo_level change
    bus.req_ready = 1'b0; fifo_level = 7'd0;
    wait_req_valid(10, "bp_wait");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) fifo_level = 7'd60;
      chk("bp_valid_hold", 64'(bus.req_valid), 64'd1);
      chk("bp_addr_hold", 64'(bus.req_addr), 64'h2080);
      tick(1);
    end
    bus.req_ready = 1'b1;
    tick(1);
    bus.req_ready = 1'b0;
    chk("bp_addr_adv", 64'(bus.req_addr), 64'h20C0);
    tick(3);
    chk("bp_single_accept", 64'(accepts - acc0), 64'd3);
    chk("bp_inflight", 64'(dut.inflight), 64'd2);

    // Simultaneous accept and completion
    fifo_level = 7'd0;
    wait_req_valid(10, "sim_wait");
    bus.req_ready = 1'b1; man_rsp = 1'b1;
    tick(1);
    bus.req_ready = 1'b0; man_rsp = 1'b0;
    chk("sim_inflight", 64'(dut.inflight), 64'd2);
    chk("sim_accepts", 64'(accepts - acc0), 64'd4);
    repeat (2) begin
      man_rsp = 1'b1;
      tick(1);
      man_rsp = 1'b0;
      tick(1);
    end
    chk("sim_drained", 64'(dut.inflight), 64'd0);
    auto_en = 1'b1; bus.req_ready = 1'b1;
    wait_frame_done(200, "f2_done");
    chk("f2_sb_empty", 64'(sb.size()), 64'd0);

    // Overrun: VS falls again mid-fetch
    chk("ovr_clear", 64'(err_overrun), 64'd0);
    fb_base = 32'h3000;
    push_frame(32'h3000);
    vs_in = 1'b0;
    tick(1);
    vs_in = 1'b1;
    tick(6);
    vs_in = 1'b0;
    tick(1);
    vs_in = 1'b1;
    chk("ovr_set", 64'(err_overrun), 64'd1);
    wait_frame_done(200, "f3_done");
    chk("f3_sb_empty", 64'(sb.size()), 64'd0);
    acc0 = accepts;
    tick(10);
    chk("ovr_sticky", 64'(err_overrun), 64'd1);
    chk("ovr_no_restart", 64'(frame_active), 64'd0);
    chk("ovr_state", 64'(dut.state_q), 64'(SYNC));
    chk("ovr_no_req", 64'(accepts - acc0), 64'd0);

    // Enable dropped mid-frame
    fb_base = 32'h4000;
    push_frame(32'h4000);
    vs_in = 1'b0;
    tick(1);
    vs_in = 1'b1;
    tick(3);
    enable = 1'b0;
    wait_frame_done(200, "f4_done");
    chk("f4_sb_empty", 64'(sb.size()), 64'd0);
    chk("f4_idle", 64'(dut.state_q), 64'(IDLE));
    acc0 = accepts;
    vs_in = 1'b0;
    tick(2);
    vs_in = 1'b1;
    tick(20);
    chk("f4_no_req", 64'(accepts - acc0), 64'd0);
    chk("f4_valid_low", 64'(bus.req_valid), 64'd0);
    chk("f4_inactive", 64'(frame_active), 64'd0);

    // Reset during an outstanding request
    auto_en = 1'b0; bus.req_ready = 1'b0; enable = 1'b1; fb_base = 32'h5000;
    tick(2);
    sb.push_back(64'h5000);
    vs_in = 1'b0;
    tick(1);
    vs_in = 1'b1;
    wait_req_valid(10, "mr_wait1");
    bus.req_ready = 1'b1;
    tick(1);
    bus.req_ready = 1'b0;
    wait_req_valid(10, "mr_wait2");
    chk("mr_inflight_pre", 64'(dut.inflight), 64'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mr_valid", 64'(bus.req_valid), 64'd0);
    chk("mr_addr", 64'(bus.req_addr), 64'd0);
    chk("mr_inflight", 64'(dut.inflight), 64'd0);
    chk("mr_active", 64'(frame_active), 64'd0);
    chk("mr_ovr", 64'(err_overrun), 64'd0);
    chk("mr_state", 64'(dut.state_q), 64'(IDLE));
    man_rsp = 1'b1;
    tick(1);
    man_rsp = 1'b0;
    chk("mr_late_rsp", 64'(dut.inflight), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
